// File: rtl/bats_pitch_encoder_if.sv
// Command and byte-stream bundle for the BATS PITCH encoder.
// The master side issues commands and sinks bytes; the slave side is the encoder.
interface bats_pitch_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] orderbook_command;
    logic [63:0] order_id;
    logic [7:0]  side;
    logic [31:0] quantity;
    logic [63:0] symbol;
    logic [63:0] price;
    logic [31:0] executed_quantity;
    logic [31:0] cancelled_quantity;
    logic [31:0] time_offset;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_last;
    logic        data_ready;
    logic        cmd_error;

    modport master (
        output cmd_valid, orderbook_command, order_id, side, quantity, symbol,
               price, executed_quantity, cancelled_quantity, time_offset, data_ready,
        input  cmd_ready, data_out, data_valid, data_last, cmd_error
    );

    modport slave (
        input  cmd_valid, orderbook_command, order_id, side, quantity, symbol,
               price, executed_quantity, cancelled_quantity, time_offset, data_ready,
        output cmd_ready, data_out, data_valid, data_last, cmd_error
    );
endinterface

// File: rtl/bats_pitch_encoder.sv
// BATS binary Multicast PITCH encoder: one command in, one sequenced-unit
// payload (8-byte header + one message) out as a little-endian byte stream.
module bats_pitch_encoder #(
    parameter logic [7:0] UNIT      = 8'h01,
    parameter logic [7:0] ADD_FLAGS = 8'h00
) (
    input  logic                      Clk40Derived2x1I0MHz,
    input  logic                      reset,
    bats_pitch_encoder_if.slave       bus
);

    localparam logic [15:0] CMD_ADD    = 16'd1;
    localparam logic [15:0] CMD_EXEC   = 16'd2;
    localparam logic [15:0] CMD_REDUCE = 16'd3;
    localparam logic [15:0] CMD_DELETE = 16'd4;

    typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;

    // Whole payload length in bytes; zero marks an unsupported command.
    function automatic logic [5:0] payload_len(input logic [15:0] cmd);
        case (cmd)
            CMD_ADD:    payload_len = 6'd42;
            CMD_EXEC:   payload_len = 6'd34;
            CMD_REDUCE: payload_len = 6'd26;
            CMD_DELETE: payload_len = 6'd22;
            default:    payload_len = 6'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        data_last_q, data_last_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cmd_error_q, cmd_error_d;
    logic [31:0] seq_q, seq_d;
    logic [63:0] exec_id_q, exec_id_d;

    logic [15:0] cmd_q, cmd_d;
    logic [63:0] oid_q, oid_d;
    logic [7:0]  side_q, side_d;
    logic [31:0] qty_q, qty_d;
    logic [47:0] sym_q, sym_d;
    logic [63:0] price_q, price_d;
    logic [31:0] exq_q, exq_d;
    logic [31:0] cxq_q, cxq_d;
    logic [31:0] tofs_q, tofs_d;
    logic [5:0]  last_idx_q, last_idx_d;

    logic         accept;
    logic [335:0] payload;
    logic         unused_sym_hi;

    assign accept        = bus.cmd_valid && cmd_ready_q;
    assign unused_sym_hi = ^bus.symbol[63:48];

    // Capture command fields on the accept edge; hold them for the whole payload.
    always_comb begin
        cmd_d      = cmd_q;
        oid_d      = oid_q;
        side_d     = side_q;
        qty_d      = qty_q;
        sym_d      = sym_q;
        price_d    = price_q;
        exq_d      = exq_q;
        cxq_d      = cxq_q;
        tofs_d     = tofs_q;
        last_idx_d = last_idx_q;
        if (accept) begin
            cmd_d      = bus.orderbook_command;
            oid_d      = bus.order_id;
            side_d     = bus.side;
            qty_d      = bus.quantity;
            sym_d      = bus.symbol[47:0];
            price_d    = bus.price;
            exq_d      = bus.executed_quantity;
            cxq_d      = bus.cancelled_quantity;
            tofs_d     = bus.time_offset;
            last_idx_d = payload_len(bus.orderbook_command) - 6'd1;
        end
    end

    // Lay out the full payload as a flat vector, byte k at bits [8k+7:8k].
    // Built from the next-state fields so byte 0 is ready on the accept edge.
    always_comb begin
        payload = '0;
        case (cmd_d)
            CMD_ADD:    payload = {ADD_FLAGS, price_d, sym_d, qty_d, side_d, oid_d, tofs_d,
                                   8'h21, 8'h22, seq_q, UNIT, 8'h01, 16'd42};
            CMD_EXEC:   payload = {64'h0, exec_id_q, exq_d, oid_d, tofs_d,
                                   8'h23, 8'h1A, seq_q, UNIT, 8'h01, 16'd34};
            CMD_REDUCE: payload = {128'h0, cxq_d, oid_d, tofs_d,
                                   8'h25, 8'h12, seq_q, UNIT, 8'h01, 16'd26};
            CMD_DELETE: payload = {160'h0, oid_d, tofs_d,
                                   8'h29, 8'h0E, seq_q, UNIT, 8'h01, 16'd22};
            default:    payload = '0;
        endcase
    end

    // Sequencer: accept in IDLE, step one byte per output handshake, bump counters at the end.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        data_last_d  = data_last_q;
        cmd_ready_d  = cmd_ready_q;
        cmd_error_d  = 1'b0;
        seq_d        = seq_q;
        exec_id_d    = exec_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (payload_len(bus.orderbook_command) != 6'd0) begin
                        state_d      = HEADER;
                        idx_d        = 6'd0;
                        data_out_d   = payload[7:0];
                        data_valid_d = 1'b1;
                        data_last_d  = 1'b0;
                        cmd_ready_d  = 1'b0;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            HEADER, BODY: begin
                if (data_valid_q && bus.data_ready) begin
                    if (idx_q == last_idx_q) begin
                        state_d      = IDLE;
                        data_valid_d = 1'b0;
                        data_last_d  = 1'b0;
                        cmd_ready_d  = 1'b1;
                        seq_d        = seq_q + 32'd1;
                        if (cmd_q == CMD_EXEC) begin
                            exec_id_d = exec_id_q + 64'd1;
                        end
                    end else begin
                        idx_d       = idx_q + 6'd1;
                        data_out_d  = payload[{idx_d, 3'b000} +: 8];
                        data_last_d = (idx_d == last_idx_q);
                        state_d     = (idx_d < 6'd8) ? HEADER : BODY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers, cleared by the synchronous active-low reset.
    always_ff @(posedge Clk40Derived2x1I0MHz) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= 6'd0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            cmd_error_q  <= 1'b0;
            seq_q        <= 32'd1;
            exec_id_q    <= 64'd1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            cmd_ready_q  <= cmd_ready_d;
            cmd_error_q  <= cmd_error_d;
            seq_q        <= seq_d;
            exec_id_q    <= exec_id_d;
        end
    end

    // Command field storage; never read outside a payload, so it needs no reset.
    always_ff @(posedge Clk40Derived2x1I0MHz) begin
        cmd_q      <= cmd_d;
        oid_q      <= oid_d;
        side_q     <= side_d;
        qty_q      <= qty_d;
        sym_q      <= sym_d;
        price_q    <= price_d;
        exq_q      <= exq_d;
        cxq_q      <= cxq_d;
        tofs_q     <= tofs_d;
        last_idx_q <= last_idx_d;
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.data_last  = data_last_q;
    assign bus.cmd_error  = cmd_error_q;

endmodule

// File: tb/tb_bats_pitch_encoder.sv
// Scoreboard bench for bats_pitch_encoder: expected bytes are queued when a
// command is driven and popped as the encoder hands bytes over.
module tb_bats_pitch_encoder;

    localparam logic [7:0] TB_UNIT  = 8'h01;
    localparam logic [7:0] TB_FLAGS = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bats_pitch_encoder_if bus ();

    bats_pitch_encoder #(.UNIT(TB_UNIT), .ADD_FLAGS(TB_FLAGS)) dut (
        .Clk40Derived2x1I0MHz(clk),
        .reset(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [8:0]  exp_q[$];
    logic [7:0]  pl_q[$];
    logic [31:0] m_seq = 32'd1;
    logic [63:0] m_eid = 64'd1;

    int   popped = 0;
    int   pos = 0;
    int   cyc = 0;
    int   last_end_cyc = 0;
    int   start_gap = 0;
    bit   hold_armed = 1'b0;
    logic [9:0] held = '0;

    logic [7:0] add_ref [42] = '{
        8'h2A, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00,
        8'h22, 8'h21, 8'h44, 8'h33, 8'h22, 8'h11,
        8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01,
        8'h42, 8'h64, 8'h00, 8'h00, 8'h00,
        8'h41, 8'h41, 8'h50, 8'h4C, 8'h20, 8'h20,
        8'h60, 8'hE3, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic le(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) pl_q.push_back(v[8*i +: 8]);
    endtask

    // Reference payload built byte by byte from the command fields.
    task automatic model_push(input logic [15:0] c, input logic [63:0] oid, input logic [7:0] sd,
                              input logic [31:0] q, input logic [63:0] sym, input logic [63:0] pr,
                              input logic [31:0] exq, input logic [31:0] cxq, input logic [31:0] to);
        int len;
        logic [7:0] typ;
        case (c)
            16'd1:   begin len = 34; typ = 8'h21; end
            16'd2:   begin len = 26; typ = 8'h23; end
            16'd3:   begin len = 18; typ = 8'h25; end
            16'd4:   begin len = 14; typ = 8'h29; end
            default: return;
        endcase
        pl_q.delete();
        le(64'(8 + len), 2);
        le(64'h01, 1);
        le(64'(TB_UNIT), 1);
        le(64'(m_seq), 4);
        le(64'(len), 1);
        le(64'(typ), 1);
        le(64'(to), 4);
        le(oid, 8);
        case (c)
            16'd1: begin le(64'(sd), 1); le(64'(q), 4); le(sym, 6); le(pr, 8); le(64'(TB_FLAGS), 1); end
            16'd2: begin le(64'(exq), 4); le(m_eid, 8); m_eid = m_eid + 64'd1; end
            16'd3: le(64'(cxq), 4);
            default: ;
        endcase
        m_seq = m_seq + 32'd1;
        for (int i = 0; i < pl_q.size(); i++)
            exp_q.push_back({(i == pl_q.size() - 1), pl_q[i]});
    endtask

    task automatic send(input logic [15:0] c, input logic [63:0] oid, input logic [7:0] sd,
                        input logic [31:0] q, input logic [63:0] sym, input logic [63:0] pr,
                        input logic [31:0] exq, input logic [31:0] cxq, input logic [31:0] to,
                        input bit use_model);
        int k;
        bus.orderbook_command  = c;
        bus.order_id           = oid;
        bus.side               = sd;
        bus.quantity           = q;
        bus.symbol             = sym;
        bus.price              = pr;
        bus.executed_quantity  = exq;
        bus.cancelled_quantity = cxq;
        bus.time_offset        = to;
        bus.cmd_valid          = 1'b1;
        if (use_model) model_push(c, oid, sd, q, sym, pr, exq, cxq, to);
        k = 0;
        @(negedge clk);
        while (!bus.cmd_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!bus.cmd_ready) chk("accept_timeout", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid          = 1'b0;
        bus.orderbook_command  = 16'($urandom);
        bus.order_id           = {$urandom, $urandom};
        bus.side               = 8'($urandom);
        bus.quantity           = $urandom;
        bus.symbol             = {$urandom, $urandom};
        bus.price              = {$urandom, $urandom};
        bus.executed_quantity  = $urandom;
        bus.cancelled_quantity = $urandom;
        bus.time_offset        = $urandom;
    endtask

    task automatic drain(input bit rnd);
        int k = 0;
        while ((exp_q.size() != 0 || bus.data_valid) && k < 5000) begin
            @(posedge clk);
            #1;
            if (rnd) bus.data_ready = 1'($urandom_range(0, 1));
            k++;
        end
        bus.data_ready = 1'b1;
        if (k >= 5000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.data_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        pos   = 0;
        m_seq = 32'd1;
        m_eid = 64'd1;
    endtask

    // Byte monitor: sampled on the falling edge, ahead of the edge that transfers.
    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        if (!rst_n) begin
            hold_armed = 1'b0;
        end else begin
            if (hold_armed) chk("stall_hold", 64'({bus.data_last, bus.data_valid, bus.data_out}), 64'(held));
            hold_armed = bus.data_valid && !bus.data_ready;
            held       = {bus.data_last, bus.data_valid, bus.data_out};
            if (bus.data_valid && bus.data_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_byte", 64'(bus.data_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("byte%0d", pos), 64'({bus.data_last, bus.data_out}), 64'(e));
                    if (pos == 0) start_gap = cyc - last_end_cyc;
                    pos++;
                    popped++;
                    if (e[8]) begin
                        pos = 0;
                        last_end_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        logic [15:0] c;

        bus.cmd_valid  = 1'b0;
        bus.data_ready = 1'b1;
        bus.orderbook_command = '0;
        bus.order_id = '0; bus.side = '0; bus.quantity = '0; bus.symbol = '0;
        bus.price = '0; bus.executed_quantity = '0; bus.cancelled_quantity = '0; bus.time_offset = '0;

        reset_dut();
        chk("rst_cmd_ready",  64'(bus.cmd_ready), 64'd1);
        chk("rst_data_valid", 64'(bus.data_valid), 64'd0);
        chk("rst_data_last",  64'(bus.data_last), 64'd0);
        chk("rst_data_out",   64'(bus.data_out), 64'h00);
        chk("rst_cmd_error",  64'(bus.cmd_error), 64'd0);

        // Add after reset against the literal reference stream.
        for (int i = 0; i < 42; i++) exp_q.push_back({(i == 41), add_ref[i]});
        m_seq = m_seq + 32'd1;
        send(16'd1, 64'h0102030405060708, 8'h42, 32'd100, 64'h0000_2020_4C50_4141,
             64'd1500000, 32'd0, 32'd0, 32'h11223344, 1'b0);
        chk("busy_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("first_valid", 64'(bus.data_valid), 64'd1);
        drain(1'b0);

        // Delete then Execute back to back.
        reset_dut();
        send(16'd4, 64'hDEAD_BEEF_0000_0004, 8'h53, 32'd0, 64'd0, 64'd0, 32'd0, 32'd0, 32'h0000_0100, 1'b1);
        send(16'd2, 64'hDEAD_BEEF_0000_0002, 8'h42, 32'd0, 64'd0, 64'd0, 32'd77, 32'd0, 32'h0000_0200, 1'b1);
        drain(1'b0);
        chk("b2b_gap", 64'(start_gap), 64'd2);

        // Reduce under random backpressure.
        bus.data_ready = 1'b0;
        send(16'd3, 64'h1111_2222_3333_4444, 8'h42, 32'd0, 64'd0, 64'd0, 32'd0, 32'h0000ABCD, 32'h5555_6666, 1'b1);
        drain(1'b1);

        // Unsupported command: error pulse only.
        send(16'd7, 64'h1, 8'h42, 32'd1, 64'd0, 64'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        chk("err_pulse", 64'(bus.cmd_error), 64'd1);
        chk("err_ready", 64'(bus.cmd_ready), 64'd1);
        chk("err_no_valid", 64'(bus.data_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("err_clear", 64'(bus.cmd_error), 64'd0);
        chk("err_no_valid2", 64'(bus.data_valid), 64'd0);
        send(16'd4, 64'hABCD_0000_0000_0007, 8'h53, 32'd0, 64'd0, 64'd0, 32'd0, 32'd0, 32'h7, 1'b1);
        drain(1'b0);

        // Reset while byte 10 of an Add is presented.
        base = popped;
        send(16'd1, 64'hCAFE_0000_0000_0001, 8'h53, 32'd5, 64'h0000_2020_2020_5A58,
             64'd123456, 32'd0, 32'd0, 32'h99, 1'b1);
        k = 0;
        while (popped < base + 10 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reset_reach_byte10", 64'(popped - base), 64'd10);
        rst_n = 1'b0;
        bus.data_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(bus.data_valid), 64'd0);
        chk("midrst_last",  64'(bus.data_last), 64'd0);
        chk("midrst_ready", 64'(bus.cmd_ready), 64'd1);
        rst_n = 1'b1;
        bus.data_ready = 1'b1;
        exp_q.delete();
        pos   = 0;
        m_seq = 32'd1;
        m_eid = 64'd1;
        send(16'd2, 64'h0BAD_F00D_0000_0001, 8'h42, 32'd0, 64'd0, 64'd0, 32'd9, 32'd0, 32'h1, 1'b1);
        drain(1'b0);

        // Random command stream, mostly back to back.
        for (int i = 0; i < 200; i++) begin
            c = 16'($urandom_range(1, 4));
            send(c, {$urandom, $urandom}, ($urandom_range(0, 1) != 0) ? 8'h42 : 8'h53, $urandom,
                 {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, $urandom, 1'b1);
            if (i % 10 == 9) drain(i % 20 == 19);
        end
        drain(1'b0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
